// File: rtl/hamming_secded_encoder_stream_if.sv
// Stream bundle for the SECDED encoder: input word side and output codeword side.
interface hamming_secded_encoder_stream_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CODE_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CODE_W-1:0] inj_mask;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;
  logic              out_injected;

  modport slave (
    input  in_valid, in_data, inj_mask, out_ready,
    output in_ready, out_valid, out_code, out_injected
  );

  modport master (
    output in_valid, in_data, inj_mask, out_ready,
    input  in_ready, out_valid, out_code, out_injected
  );
endinterface

// File: rtl/hamming_secded_encoder_stream.sv
// Registered SECDED (extended Hamming) encoder with valid/ready stream handshake,
// per-word error injection and a saturating accepted-word counter.
module hamming_secded_encoder_stream #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  hamming_secded_encoder_stream_if.slave  bus,
  output logic [CNT_W-1:0]                word_count
);

  function automatic int unsigned par_width(input int unsigned dw);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  localparam int unsigned PAR_W  = par_width(DATA_W);
  localparam int unsigned CODE_W = DATA_W + PAR_W + 1;

  logic [CODE_W-1:0] clean;
  logic              take_in;
  logic              take_out;

  // Data fills non-power-of-two positions in order, then each parity covers
  // the positions whose index has its bit set; overall parity goes on top.
  always_comb begin
    int unsigned di;
    clean = '0;
    di    = 0;
    for (int unsigned k = 1; k < CODE_W; k++) begin
      if ((k & (k - 1)) != 0) begin
        clean[k-1] = bus.in_data[di];
        di++;
      end
    end
    for (int unsigned p = 0; p < PAR_W; p++) begin
      for (int unsigned k = 1; k < CODE_W; k++) begin
        if (k[p] && ((k & (k - 1)) != 0)) clean[(1 << p) - 1] ^= clean[k-1];
      end
    end
    clean[CODE_W-1] = ^clean[CODE_W-2:0];
  end

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign take_in      = bus.in_valid && bus.in_ready;
  assign take_out     = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid    <= 1'b0;
      bus.out_code     <= '0;
      bus.out_injected <= 1'b0;
      word_count       <= '0;
    end else begin
      if (take_in) begin
        bus.out_code     <= clean ^ bus.inj_mask;
        bus.out_injected <= |bus.inj_mask;
        bus.out_valid    <= 1'b1;
      end else if (take_out) begin
        bus.out_valid    <= 1'b0;
      end
      if (take_in && (word_count != '1)) word_count <= word_count + 1'b1;
    end
  end

endmodule

// File: doc/hamming_secded_encoder_stream.md
Name: hamming_secded_encoder_stream

Overview:
Parametrised, registered SECDED (extended Hamming) encoder with valid/ready streaming handshake on both sides. It sits between the data source (switches/UART/test pattern) and the channel/decoder path. It generalises the 4-bit combinational encoder to any data width. It adds a one-stage output register with backpressure, a per-word fault-injection mask for exercising the downstream decoder, and a saturating accepted-word counter.

Parameters:
DATA_W, 4, data bits per word; legal range 1..57.
CNT_W, 16, width of accepted-word counter.
Derived (localparam, not overridable): PAR_W = smallest r with 2^r >= DATA_W + r + 1; CODE_W = DATA_W + PAR_W + 1. For DATA_W=4: PAR_W=3, CODE_W=8. For DATA_W=8: PAR_W=4, CODE_W=13.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  source presents a word.
in_ready  out  1  encoder can accept this cycle.
in_data  in  DATA_W  data word, d0 = bit 0.
inj_mask  in  CODE_W  bits XORed into the codeword; sampled with in_data; all-zero means no injection.
out_valid  out  1  codeword held in output register.
out_ready  in  1  sink accepts codeword.
out_code  out  CODE_W  encoded word (+ injected errors).
out_injected  out  1  1 if the held word's inj_mask was nonzero.
word_count  out  CNT_W  number of accepted words, saturating.

Behaviour:
- Codeword layout: Hamming position k (1-based, 1..CODE_W-1) maps to out_code[k-1]. Power-of-two positions (1,2,4,8,…) carry parity p_k. Data bits d0,d1,… fill the remaining positions in ascending order. out_code[CODE_W-1] is overall parity.
- p_k = XOR of all data bits whose position has bit log2(k) set. Overall parity = XOR of out_code[CODE_W-2:0], so the total codeword has even parity.
- For DATA_W=4 the layout is exactly [0]=p1,[1]=p2,[2]=d0,[3]=p4,[4]=d1,[5]=d2,[6]=d3,[7]=p_all.
- Injection: the stored word is the clean codeword XOR inj_mask, with the mask applied after overall parity is computed. A 1-bit mask yields a single error; a 2-bit mask yields a double error.
- Handshake: in_ready = !out_valid || out_ready (combinational). Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
- Latency is 1 cycle: a word accepted at edge N appears on out_code with out_valid=1 after edge N.
- Throughput: 1 word/cycle while out_ready=1.
- Simultaneous out transfer and in transfer in the same cycle: the register loads the new word and out_valid stays 1, with no bubble.
- out transfer without an in transfer: out_valid goes to 0 at the next edge.
- Stall: while out_valid && !out_ready, out_code and out_injected hold stable, in_ready=0, and in_data/inj_mask are ignored.
- out_code and out_injected change only on an in transfer.
- word_count increments by 1 per in transfer and saturates at 2^CNT_W-1 (no wrap).
- Reset: out_valid=0, out_code=0, out_injected=0, word_count=0. in_ready=1 in the cycle after reset deasserts.
- While rst=1, no transfer is counted or stored. Reset mid-stall discards the held word.
- No internal state machine beyond the out_valid flag. in_valid must stay asserted until accepted; data and mask must stay stable while in_valid && !in_ready.

Test Plan:
1. DATA_W=4, out_ready=1, mask=0; in_data 4'h0, 4'hB, 4'hF on consecutive cycles -> out_code 8'h00, 8'h55, 8'hFF on the following cycles. out_valid stays 1 throughout, and word_count reaches 3.
2. DATA_W=4, in_data=4'hB, inj_mask=8'h04 -> out_code=8'h51, out_injected=1. Next word with mask=8'h00 -> out_injected=0.
3. Backpressure: hold out_ready=0 for 3 cycles after the first word, with in_valid=1 and data 4'h3 then 4'h7 -> in_ready=0 and out_code frozen during the stall. After release, both words emerge in order with no loss or duplication, and word_count=2.
4. DATA_W=8 (CODE_W=13), in_data=8'h01 -> out_code=13'h1007. in_data=8'h00 -> 13'h0000. Exhaustive 256-value check: a reference model confirms each codeword has even total parity and a zero syndrome.
5. Reset during stall: out_valid=1, out_ready=0, assert rst for one cycle -> next cycle out_valid=0, out_code=0, word_count=0, in_ready=1.
6. CNT_W=3, 10 back-to-back transfers -> word_count reads 7 and holds at 7.
